// File: rtl/data_mem_responder.sv
// Word-organised data memory responder with valid/ready request and response channels.
// Optional address range checking with rsp_err is enabled by defining DMEM_RANGE_CHK_EN.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata
`ifdef DMEM_RANGE_CHK_EN
  ,
  output logic              rsp_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [3:0]       cnt_r;
  logic [3:0]       cnt_s;
  logic [31:0]      mem_r [DEPTH_WORDS];
  logic [IDX_W-1:0] idx_s;
  logic             accept_s;
  logic             oob_s;
  logic             write_en_s;
  logic             unused_addr_s;

  // Lanes with a set mask bit take the new byte, the rest keep the old one.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] result;
    result = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) begin
        result[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        result[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return result;
  endfunction

  assign idx_s         = req_addr[IDX_W+1:2];
  assign unused_addr_s = ^{req_addr[1:0], req_addr[ADDR_W-1:IDX_W+2]};

`ifdef DMEM_RANGE_CHK_EN
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(64'(DEPTH_WORDS) << 2);
  assign oob_s = ({1'b0, req_addr} >= ADDR_LIMIT);
`else
  assign oob_s = 1'b0;
`endif

  // Reset wins over a simultaneous request: nothing is accepted or written.
  assign accept_s   = req_valid && req_ready && !rst;
  assign write_en_s = accept_s && req_we && !oob_s;

  // Next-state and latency countdown
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (LATENCY > 1) begin
            state_s = ST_WAIT;
            cnt_s   = 4'(LATENCY - 1);
          end else begin
            state_s = ST_RESP;
            cnt_s   = 4'd0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_s = ST_RESP;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State register and registered handshake/data outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      req_ready <= (state_s == ST_IDLE);
      rsp_valid <= (state_s == ST_RESP);
      if (accept_s) begin
        rsp_rdata <= (req_we || oob_s) ? 32'h0 : mem_r[idx_s];
      end else if ((state_r == ST_RESP) && rsp_ready) begin
        rsp_rdata <= 32'h0;
      end
    end
  end

`ifdef DMEM_RANGE_CHK_EN
  logic err_pend_r;

  // Error flag is held internally and only shown while the response is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pend_r <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept_s) begin
        err_pend_r <= oob_s;
      end
      if (state_s == ST_RESP) begin
        rsp_err <= accept_s ? oob_s : err_pend_r;
      end else begin
        rsp_err <= 1'b0;
      end
    end
  end
`endif

  // Array is not reset; a store commits at its accept edge.
  always_ff @(posedge clk) begin
    if (write_en_s) begin
      mem_r[idx_s] <= merge_bytes(mem_r[idx_s], req_wdata, req_wmask);
    end
  end

endmodule
